inst_buf: RTL and testbench

Dual-wide in-order instruction queue between fetch and decode. It absorbs fetch bursts and decode back-pressure, and presents up to two oldest instructions per cycle to the decode stage, which hands them to immediate generation and control decode. It is flushed on redirect (branch mispredict or exception).

---
 rtl/inst_buf.sv | 136 +++++++++++++
 tb/tb_inst_buf.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_buf.sv
// Dual-wide in-order instruction queue between fetch and decode, flushed on redirect.
// Optional same-cycle fetch-to-decode bypass on an empty queue: define INST_BUF_BYPASS_EN.

`ifndef RV32_INST_WIDTH
`define RV32_INST_WIDTH 32
`endif
`ifndef RV32_DATA_WIDTH
`define RV32_DATA_WIDTH 32
`endif

module inst_buf #(
    parameter int DEPTH = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_flush,
    input  logic                        i_enq_vld_0,
    input  logic                        i_enq_vld_1,
    input  logic [`RV32_INST_WIDTH-1:0] i_enq_inst_0,
    input  logic [`RV32_INST_WIDTH-1:0] i_enq_inst_1,
    input  logic [`RV32_DATA_WIDTH-1:0] i_enq_pc_0,
    input  logic [`RV32_DATA_WIDTH-1:0] i_enq_pc_1,
    output logic                        o_enq_rdy,
    output logic                        o_deq_vld_0,
    output logic                        o_deq_vld_1,
    output logic [`RV32_INST_WIDTH-1:0] o_deq_inst_0,
    output logic [`RV32_INST_WIDTH-1:0] o_deq_inst_1,
    output logic [`RV32_DATA_WIDTH-1:0] o_deq_pc_0,
    output logic [`RV32_DATA_WIDTH-1:0] o_deq_pc_1,
    input  logic                        i_deq_rdy_0,
    input  logic                        i_deq_rdy_1
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int INST_W = `RV32_INST_WIDTH;
    localparam int PC_W   = `RV32_DATA_WIDTH;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [INST_W-1:0] inst_mem [DEPTH];
    logic [PC_W-1:0]   pc_mem   [DEPTH];

    ptr_t head;
    ptr_t tail;
    cnt_t count;

    ptr_t head_1;
    ptr_t tail_1;

    logic       enq_ok;
    logic [1:0] enq_n;
    logic       deq0;
    logic       deq1;
    logic [1:0] deq_n;
    logic [1:0] wr_n;
    logic [1:0] rd_n;
    logic       wr_from_1;

    assign head_1 = head + ptr_t'(1);
    assign tail_1 = tail + ptr_t'(1);

    // Readiness looks only at registered occupancy, so a same-cycle dequeue never opens room.
    assign o_enq_rdy = (count <= cnt_t'(DEPTH - 2));

    // A lone slot-1 valid is malformed and is treated as no enqueue at all.
    assign enq_ok = o_enq_rdy & ~i_flush & i_enq_vld_0;
    assign enq_n  = enq_ok ? (i_enq_vld_1 ? 2'd2 : 2'd1) : 2'd0;

    always_comb begin
        o_deq_vld_0  = ~i_flush & (count != '0);
        o_deq_vld_1  = ~i_flush & (count >= cnt_t'(2));
        o_deq_inst_0 = inst_mem[head];
        o_deq_pc_0   = pc_mem[head];
        o_deq_inst_1 = inst_mem[head_1];
        o_deq_pc_1   = pc_mem[head_1];
`ifdef INST_BUF_BYPASS_EN
        if ((count == '0) && !i_flush) begin
            o_deq_vld_0  = i_enq_vld_0;
            o_deq_vld_1  = i_enq_vld_1;
            o_deq_inst_0 = i_enq_inst_0;
            o_deq_pc_0   = i_enq_pc_0;
            o_deq_inst_1 = i_enq_inst_1;
            o_deq_pc_1   = i_enq_pc_1;
        end
`endif
    end

    // Slot 1 is only ever taken together with slot 0 to keep decode in order.
    assign deq0  = o_deq_vld_0 & i_deq_rdy_0;
    assign deq1  = deq0 & o_deq_vld_1 & i_deq_rdy_1;
    assign deq_n = {1'b0, deq0} + {1'b0, deq1};

    always_comb begin
        wr_n      = enq_n;
        rd_n      = deq_n;
        wr_from_1 = 1'b0;
`ifdef INST_BUF_BYPASS_EN
        // Bypassed slots that decode took this cycle never land in storage.
        if ((count == '0) && !i_flush) begin
            wr_n      = enq_n - deq_n;
            rd_n      = 2'd0;
            wr_from_1 = deq0;
        end
`endif
    end

    always_ff @(posedge i_clk) begin
        if (wr_n != 2'd0) begin
            inst_mem[tail] <= wr_from_1 ? i_enq_inst_1 : i_enq_inst_0;
            pc_mem[tail]   <= wr_from_1 ? i_enq_pc_1   : i_enq_pc_0;
        end
        if (wr_n == 2'd2) begin
            inst_mem[tail_1] <= i_enq_inst_1;
            pc_mem[tail_1]   <= i_enq_pc_1;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (i_flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + ptr_t'(rd_n);
            tail  <= tail + ptr_t'(wr_n);
            count <= count + cnt_t'(wr_n) - cnt_t'(rd_n);
        end
    end

endmodule

// File: tb/tb_inst_buf.sv
// Directed bench for inst_buf: per-cycle expectations plus an in-order consumption scoreboard.

module tb_inst_buf;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        enq_vld_0, enq_vld_1;
    logic [31:0] enq_inst_0, enq_inst_1, enq_pc_0, enq_pc_1;
    logic        enq_rdy;
    logic        deq_vld_0, deq_vld_1;
    logic [31:0] deq_inst_0, deq_inst_1, deq_pc_0, deq_pc_1;
    logic        deq_rdy_0, deq_rdy_1;

    inst_buf #(.DEPTH(8)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_flush      (flush),
        .i_enq_vld_0  (enq_vld_0),
        .i_enq_vld_1  (enq_vld_1),
        .i_enq_inst_0 (enq_inst_0),
        .i_enq_inst_1 (enq_inst_1),
        .i_enq_pc_0   (enq_pc_0),
        .i_enq_pc_1   (enq_pc_1),
        .o_enq_rdy    (enq_rdy),
        .o_deq_vld_0  (deq_vld_0),
        .o_deq_vld_1  (deq_vld_1),
        .o_deq_inst_0 (deq_inst_0),
        .o_deq_inst_1 (deq_inst_1),
        .o_deq_pc_0   (deq_pc_0),
        .o_deq_pc_1   (deq_pc_1),
        .i_deq_rdy_0  (deq_rdy_0),
        .i_deq_rdy_1  (deq_rdy_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          cyc;
        string       name;
        bit          chk_ctl;
        bit          chk_d0;
        bit          chk_d1;
        bit          v0, v1, rdy;
        logic [31:0] i0, p0, i1, p1;
    } exp_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } ord_t;

    exp_t exp_q[$];
    ord_t ord_q[$];
    bit   ord_en = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    task automatic push_exp(input string nm, input bit c, input bit d0, input bit d1,
                            input bit v0, input bit v1, input bit rdy,
                            input logic [31:0] i0, input logic [31:0] p0,
                            input logic [31:0] i1, input logic [31:0] p1);
        exp_t e;
        e.cyc = cyc; e.name = nm; e.chk_ctl = c; e.chk_d0 = d0; e.chk_d1 = d1;
        e.v0 = v0; e.v1 = v1; e.rdy = rdy;
        e.i0 = i0; e.p0 = p0; e.i1 = i1; e.p1 = p1;
        exp_q.push_back(e);
    endtask

    task automatic exp_ctl(input string nm, input bit v0, input bit v1, input bit rdy);
        push_exp(nm, 1'b1, 1'b0, 1'b0, v0, v1, rdy, '0, '0, '0, '0);
    endtask

    task automatic exp_dat(input string nm, input logic [31:0] i0, input logic [31:0] p0,
                           input logic [31:0] i1, input logic [31:0] p1);
        push_exp(nm, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, i0, p0, i1, p1);
    endtask

    task automatic exp_d0(input string nm, input logic [31:0] i0, input logic [31:0] p0);
        push_exp(nm, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, i0, p0, '0, '0);
    endtask

    task automatic ord_push(input logic [31:0] inst, input logic [31:0] pc);
        ord_t o;
        o.inst = inst; o.pc = pc;
        ord_q.push_back(o);
    endtask

    task automatic drive(input bit v0, input bit v1,
                         input logic [31:0] i0, input logic [31:0] p0,
                         input logic [31:0] i1, input logic [31:0] p1,
                         input bit r0, input bit r1, input bit fl);
        enq_vld_0 = v0; enq_vld_1 = v1;
        enq_inst_0 = i0; enq_pc_0 = p0;
        enq_inst_1 = i1; enq_pc_1 = p1;
        deq_rdy_0 = r0; deq_rdy_1 = r1;
        flush = fl;
    endtask

    task automatic idle();
        drive(0, 0, '0, '0, '0, '0, 0, 0, 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] fi(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction
    function automatic logic [31:0] fp(input int k);
        return 32'h0000_0040 + 32'(4 * k);
    endfunction

    // Monitor: sample on the falling edge, away from the registering edge.
    initial begin
        exp_t e;
        ord_t o;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
                e = exp_q.pop_front();
                if (e.chk_ctl) begin
                    cmp({e.name, ".vld0"}, 32'(deq_vld_0), 32'(e.v0));
                    cmp({e.name, ".vld1"}, 32'(deq_vld_1), 32'(e.v1));
                    cmp({e.name, ".enq_rdy"}, 32'(enq_rdy), 32'(e.rdy));
                end
                if (e.chk_d0) begin
                    cmp({e.name, ".inst0"}, deq_inst_0, e.i0);
                    cmp({e.name, ".pc0"}, deq_pc_0, e.p0);
                end
                if (e.chk_d1) begin
                    cmp({e.name, ".inst1"}, deq_inst_1, e.i1);
                    cmp({e.name, ".pc1"}, deq_pc_1, e.p1);
                end
            end
            if (ord_en && rst_n && deq_vld_0 && deq_rdy_0) begin
                if (ord_q.size() == 0) cmp("order.underflow0", 32'd1, 32'd0);
                else begin
                    o = ord_q.pop_front();
                    cmp("order.inst0", deq_inst_0, o.inst);
                    cmp("order.pc0", deq_pc_0, o.pc);
                end
                if (deq_vld_1 && deq_rdy_1) begin
                    if (ord_q.size() == 0) cmp("order.underflow1", 32'd1, 32'd0);
                    else begin
                        o = ord_q.pop_front();
                        cmp("order.inst1", deq_inst_1, o.inst);
                        cmp("order.pc1", deq_pc_1, o.pc);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        idle();

        // Reset state
        step();
        exp_ctl("rst", 0, 0, 1);
        step();
        rst_n = 1'b1;
        exp_ctl("rst_rel", 0, 0, 1);

        // First pair, one-cycle latency
        step();
        drive(1, 1, 32'h0050_0093, 32'h0, 32'h00A0_0113, 32'h4, 0, 0, 0);
`ifndef INST_BUF_BYPASS_EN
        exp_ctl("t1_same", 0, 0, 1);
`endif
        step();
        idle();
        exp_ctl("t1_next", 1, 1, 1);
        exp_dat("t1_next", 32'h0050_0093, 32'h0, 32'h00A0_0113, 32'h4);
        step();
        drive(0, 0, '0, '0, '0, '0, 1, 1, 1);
        exp_ctl("t1_flush", 0, 0, 1);
        step();
        idle();
        exp_ctl("t1_post", 0, 0, 1);

        // Fill to DEPTH with decode stalled
        for (int j = 0; j < 4; j++) begin
            step();
            drive(1, 1, fi(2*j), fp(2*j), fi(2*j+1), fp(2*j+1), 0, 0, 0);
            if (j > 0) begin
                exp_ctl($sformatf("fill%0d", j), 1, 1, 1);
                exp_dat($sformatf("fill%0d", j), fi(0), fp(0), fi(1), fp(1));
            end else begin
`ifdef INST_BUF_BYPASS_EN
                exp_ctl("fill0", 1, 1, 1);
`else
                exp_ctl("fill0", 0, 0, 1);
`endif
            end
        end
        step();
        drive(1, 1, 32'hDEAD_0001, 32'h900, 32'hDEAD_0002, 32'h904, 0, 0, 0);
        exp_ctl("fill_full", 1, 1, 0);
        exp_dat("fill_full", fi(0), fp(0), fi(1), fp(1));
        step();
        drive(0, 0, '0, '0, '0, '0, 1, 1, 0);
        exp_ctl("drain0", 1, 1, 0);
        exp_dat("drain0", fi(0), fp(0), fi(1), fp(1));
        for (int j = 1; j < 4; j++) begin
            step();
            exp_ctl($sformatf("drain%0d", j), 1, 1, 1);
            exp_dat($sformatf("drain%0d", j), fi(2*j), fp(2*j), fi(2*j+1), fp(2*j+1));
        end
        step();
        idle();
        exp_ctl("drain_empty", 0, 0, 1);

        // Steady state at count=3 with enqueue 2 / dequeue 2 across wrap
        step();
        drive(1, 1, 32'h2000_0000, 32'h100, 32'h2000_0001, 32'h104, 0, 0, 0);
        ord_push(32'h2000_0000, 32'h100);
        ord_push(32'h2000_0001, 32'h104);
        step();
        drive(1, 0, 32'h2000_0002, 32'h108, '0, '0, 0, 0, 0);
        ord_push(32'h2000_0002, 32'h108);
        exp_ctl("sim_setup", 1, 1, 1);
        for (int n = 0; n < 10; n++) begin
            step();
            drive(1, 1, 32'h3000_0000 + 32'(2*n), 32'h200 + 32'(8*n),
                  32'h3000_0001 + 32'(2*n), 32'h204 + 32'(8*n), 1, 1, 0);
            ord_push(32'h3000_0000 + 32'(2*n), 32'h200 + 32'(8*n));
            ord_push(32'h3000_0001 + 32'(2*n), 32'h204 + 32'(8*n));
            ord_en = 1'b1;
            exp_ctl($sformatf("sim%0d", n), 1, 1, 1);
        end
        step();
        drive(0, 0, '0, '0, '0, '0, 1, 1, 0);
        exp_ctl("sim_cnt3", 1, 1, 1);
        step();
        exp_ctl("sim_cnt1", 1, 0, 1);
        exp_d0("sim_cnt1", 32'h3000_0013, 32'h24C);
        step();
        idle();
        ord_en = 1'b0;
        exp_ctl("sim_empty", 0, 0, 1);

        // Slot 1 ready without slot 0 consumes nothing
        step();
        drive(1, 1, 32'h4000_0000, 32'h300, 32'h4000_0001, 32'h304, 0, 0, 0);
        step();
        drive(0, 0, '0, '0, '0, '0, 0, 1, 0);
        exp_ctl("part", 1, 1, 1);
        exp_dat("part", 32'h4000_0000, 32'h300, 32'h4000_0001, 32'h304);
        step();
        drive(1, 1, 32'h4000_0002, 32'h308, 32'h4000_0003, 32'h30C, 0, 0, 0);
        exp_ctl("part_keep", 1, 1, 1);
        exp_dat("part_keep", 32'h4000_0000, 32'h300, 32'h4000_0001, 32'h304);
        step();
        drive(1, 0, 32'h4000_0004, 32'h310, '0, '0, 0, 0, 0);
        exp_ctl("cnt4", 1, 1, 1);

        // Flush at count=5 while a pair is offered and decode is ready
        step();
        drive(1, 1, 32'h5000_0000, 32'h400, 32'h5000_0001, 32'h404, 1, 1, 1);
        exp_ctl("flush", 0, 0, 1);
        step();
        idle();
        exp_ctl("flush_post", 0, 0, 1);

        // Asynchronous reset mid-cycle drops content before any edge
        step();
        drive(1, 1, 32'h6000_0000, 32'h500, 32'h6000_0001, 32'h504, 0, 0, 0);
        step();
        idle();
        exp_ctl("pre_rst", 1, 1, 1);
        step();
        #2;
        rst_n = 1'b0;
        exp_ctl("async_rst", 0, 0, 1);
        step();
        rst_n = 1'b1;
        exp_ctl("post_rst", 0, 0, 1);

        // Empty queue, pair offered, decode takes slot 0 only
        step();
        drive(1, 1, 32'h0010_0093, 32'h200, 32'h0020_0113, 32'h204, 1, 0, 0);
`ifdef INST_BUF_BYPASS_EN
        exp_ctl("byp_same", 1, 1, 1);
        exp_dat("byp_same", 32'h0010_0093, 32'h200, 32'h0020_0113, 32'h204);
`else
        exp_ctl("byp_same", 0, 0, 1);
`endif
        step();
        idle();
`ifdef INST_BUF_BYPASS_EN
        exp_ctl("byp_next", 1, 0, 1);
        exp_d0("byp_next", 32'h0020_0113, 32'h204);
`else
        exp_ctl("byp_next", 1, 1, 1);
        exp_dat("byp_next", 32'h0010_0093, 32'h200, 32'h0020_0113, 32'h204);
`endif
        step();
        step();
        cmp("exp_q_drained", 32'(exp_q.size()), 32'd0);
        cmp("ord_q_drained", 32'(ord_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
